// File: rtl/sdf_stage_ctrl.sv
// sdf_stage_ctrl: control and feedback-memory wrapper for one radix-2 SDF FFT stage
// Ports: clk/rst (sync, active high); in_valid/in_ready/in_r/in_i accept a sample per cycle;
// delay_in_r/i is the butterfly's combinational delay return; state, din_a_*, din_b_*,
// tw_addr and stage_valid drive the butterfly and twiddle ROM.
// Optional macro SDF_FLUSH_EN adds flush (in) and busy (out) for draining the last frame.
module sdf_stage_ctrl #(
  parameter int DW        = 24,
  parameter int DEPTH     = 32,
  parameter int TW_STRIDE = 1,
  parameter int TW_AW     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef SDF_FLUSH_EN
  input  logic                 flush,
  output logic                 busy,
`endif
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_r,
  input  logic signed [DW-1:0] in_i,
  input  logic signed [DW-1:0] delay_in_r,
  input  logic signed [DW-1:0] delay_in_i,
  output logic [1:0]           state,
  output logic signed [DW-1:0] din_a_r,
  output logic signed [DW-1:0] din_a_i,
  output logic signed [DW-1:0] din_b_r,
  output logic signed [DW-1:0] din_b_i,
  output logic [TW_AW-1:0]     tw_addr,
  output logic                 stage_valid
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [1:0] state_q, state_d, phase;
  logic stage_valid_q, stage_valid_d, primed_q, primed_d;
  logic signed [DW-1:0] din_a_r_q, din_a_r_d, din_a_i_q, din_a_i_d;
  logic signed [DW-1:0] din_b_r_q, din_b_r_d, din_b_i_q, din_b_i_d;
  logic [TW_AW-1:0] tw_addr_q, tw_addr_d;
  logic [PW-1:0] ptr_q, ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic signed [DW-1:0] mem_r [DEPTH];
  logic signed [DW-1:0] mem_i [DEPTH];
  logic adv, fl_done;
  logic signed [DW-1:0] samp_r, samp_i;
`ifdef SDF_FLUSH_EN
  // While busy, the stage advances every cycle on internally generated zeros.
  logic busy_q, busy_d;
  logic [PW-1:0] fl_cnt_q, fl_cnt_d;
  assign in_ready = ~busy_q;
  assign busy     = busy_q;
  assign adv      = busy_q | in_valid;
  assign fl_done  = busy_q & (fl_cnt_q == PW'(DEPTH - 1));
  assign samp_r   = busy_q ? '0 : in_r;
  assign samp_i   = busy_q ? '0 : in_i;
  always_comb begin
    busy_d   = fl_done ? 1'b0 : (busy_q | (flush & primed_q));
    fl_cnt_d = busy_q ? fl_cnt_q + PW'(1) : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      fl_cnt_q <= '0;
    end else begin
      busy_q   <= busy_d;
      fl_cnt_q <= fl_cnt_d;
    end
  end
`else
  assign in_ready = 1'b1;
  assign adv      = in_valid;
  assign fl_done  = 1'b0;
  assign samp_r   = in_r;
  assign samp_i   = in_i;
`endif
  // cnt counts 2*DEPTH samples; its MSB separates the sum/diff half from the twiddle half.
  always_comb begin
    phase         = !primed_q ? 2'b00 : (cnt_q[PW] ? 2'b01 : 2'b10);
    state_d       = adv ? phase : 2'b11;
    stage_valid_d = adv;
    din_a_r_d     = adv ? mem_r[ptr_q] : din_a_r_q;
    din_a_i_d     = adv ? mem_i[ptr_q] : din_a_i_q;
    din_b_r_d     = adv ? samp_r : din_b_r_q;
    din_b_i_d     = adv ? samp_i : din_b_i_q;
    tw_addr_d     = adv ? TW_AW'(32'(cnt_q[PW-1:0]) * 32'(TW_STRIDE)) : tw_addr_q;
    wr_ptr_d      = adv ? ptr_q : wr_ptr_q;
    ptr_d         = fl_done ? '0 : (adv ? ptr_q + PW'(1) : ptr_q);
    cnt_d         = fl_done ? '0 : (adv ? cnt_q + CW'(1) : cnt_q);
    primed_d      = !fl_done & (primed_q | (adv & (cnt_q == CW'(DEPTH - 1))));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= 2'b00;
      stage_valid_q <= 1'b0;
      din_a_r_q     <= '0;
      din_a_i_q     <= '0;
      din_b_r_q     <= '0;
      din_b_i_q     <= '0;
      tw_addr_q     <= '0;
      wr_ptr_q      <= '0;
      ptr_q         <= '0;
      cnt_q         <= '0;
      primed_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      stage_valid_q <= stage_valid_d;
      din_a_r_q     <= din_a_r_d;
      din_a_i_q     <= din_a_i_d;
      din_b_r_q     <= din_b_r_d;
      din_b_i_q     <= din_b_i_d;
      tw_addr_q     <= tw_addr_d;
      wr_ptr_q      <= wr_ptr_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      primed_q      <= primed_d;
    end
  end
  // Butterfly result for the sample now in the din registers goes back to the slot it was read from.
  always_ff @(posedge clk) begin
    if (stage_valid_q) begin
      mem_r[wr_ptr_q] <= delay_in_r;
      mem_i[wr_ptr_q] <= delay_in_i;
    end
  end
  assign state       = state_q;
  assign stage_valid = stage_valid_q;
  assign din_a_r     = din_a_r_q;
  assign din_a_i     = din_a_i_q;
  assign din_b_r     = din_b_r_q;
  assign din_b_i     = din_b_i_q;
  assign tw_addr     = tw_addr_q;
endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// tb_sdf_stage_ctrl: scoreboard bench for sdf_stage_ctrl with DEPTH=4 and a butterfly model
module tb_sdf_stage_ctrl;
  localparam int DW = 24;
  localparam int D  = 4;
  typedef struct {
    logic [1:0] st;
    logic signed [DW-1:0] ar, ai, br, bi;
    logic [2:0] tw;
    logic [7:0] tw2;
    bit chk_a;
  } exp_t;
  logic clk = 0, rst = 1, in_valid = 0;
  logic signed [DW-1:0] in_r = 0, in_i = 0;
  logic rdy, sv, rdy2, sv2;
  logic [1:0] st, st2;
  logic signed [DW-1:0] a_r, a_i, b_r, b_i, a2_r, a2_i, b2_r, b2_i;
  logic signed [DW-1:0] dl_r, dl_i, dl2_r, dl2_i;
  logic [2:0] tw;
  logic [7:0] tw2;
`ifdef SDF_FLUSH_EN
  logic flush = 0;
  logic busy, busy2;
`endif
  int n_tests = 0, n_fail = 0;
  exp_t sb[$];
  logic signed [DW-1:0] m_r [D];
  logic signed [DW-1:0] m_i [D];
  int m_cnt = 0, m_ptr = 0;
  bit m_primed = 0;
  always #5 clk = ~clk;
  // butterfly: sum/diff state feeds back the difference, every other state stores the new sample
  assign dl_r  = (st == 2'b01) ? a_r - b_r : b_r;
  assign dl_i  = (st == 2'b01) ? a_i - b_i : b_i;
  assign dl2_r = (st2 == 2'b01) ? a2_r - b2_r : b2_r;
  assign dl2_i = (st2 == 2'b01) ? a2_i - b2_i : b2_i;
  sdf_stage_ctrl #(.DW(DW), .DEPTH(D), .TW_STRIDE(4), .TW_AW(3)) dut (
    .clk(clk), .rst(rst),
`ifdef SDF_FLUSH_EN
    .flush(flush), .busy(busy),
`endif
    .in_valid(in_valid), .in_ready(rdy), .in_r(in_r), .in_i(in_i),
    .delay_in_r(dl_r), .delay_in_i(dl_i), .state(st),
    .din_a_r(a_r), .din_a_i(a_i), .din_b_r(b_r), .din_b_i(b_i),
    .tw_addr(tw), .stage_valid(sv));
  sdf_stage_ctrl #(.DW(DW), .DEPTH(D), .TW_STRIDE(1), .TW_AW(8)) dut2 (
    .clk(clk), .rst(rst),
`ifdef SDF_FLUSH_EN
    .flush(flush), .busy(busy2),
`endif
    .in_valid(in_valid), .in_ready(rdy2), .in_r(in_r), .in_i(in_i),
    .delay_in_r(dl2_r), .delay_in_i(dl2_i), .state(st2),
    .din_a_r(a2_r), .din_a_i(a2_i), .din_b_r(b2_r), .din_b_i(b2_i),
    .tw_addr(tw2), .stage_valid(sv2));
  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic push(input logic signed [DW-1:0] r, input logic signed [DW-1:0] i);
    exp_t e;
    e.st    = !m_primed ? 2'b00 : (m_cnt < D ? 2'b10 : 2'b01);
    e.chk_a = m_primed;
    e.ar    = m_r[m_ptr];
    e.ai    = m_i[m_ptr];
    e.br    = r;
    e.bi    = i;
    e.tw    = 3'((m_cnt % D) * 4);
    e.tw2   = 8'(m_cnt % D);
    sb.push_back(e);
    m_r[m_ptr] = (e.st == 2'b01) ? e.ar - r : r;
    m_i[m_ptr] = (e.st == 2'b01) ? e.ai - i : i;
    if (m_cnt == D - 1) m_primed = 1;
    m_cnt = (m_cnt + 1) % (2 * D);
    m_ptr = (m_ptr + 1) % D;
  endtask
  task automatic model_reset();
    m_cnt = 0;
    m_ptr = 0;
    m_primed = 0;
  endtask
  task automatic drive(input bit v, input int r, input bit rs = 0, input bit z = 0);
    rst = rs;
    in_valid = v;
    in_r = DW'(r);
    in_i = DW'(-r);
    if (rs) model_reset();
    else if (z) push('0, '0);
    else if (v) push(in_r, in_i);
    @(posedge clk);
    #2;
  endtask
  always @(negedge clk) begin
    exp_t e;
    chk("sv_pair", sv2, sv);
    if (sv) begin
      if (sb.size() == 0) chk("sb_empty", 1, 0);
      else begin
        e = sb.pop_front();
        chk("state", st, e.st);
        if (e.chk_a) begin
          chk("din_a_r", a_r, e.ar);
          chk("din_a_i", a_i, e.ai);
        end
        chk("din_b_r", b_r, e.br);
        chk("din_b_i", b_i, e.bi);
        chk("tw_addr", tw, e.tw);
        chk("tw_addr2", tw2, e.tw2);
      end
    end
  end
  initial begin
    drive(0, 0, 1);
    drive(0, 0, 1);
    chk("rst_state", st, 0);
    chk("rst_valid", sv, 0);
    chk("rst_a", a_r, 0);
    chk("rst_b", b_r, 0);
    chk("rst_tw", tw2, 0);
    chk("rst_ready", rdy, 1);
    for (int k = 1; k <= 6; k++) begin
      drive(1, k);
      if (k == 5) begin
        chk("s5_a", a_r, 1);
        chk("s5_b", b_r, 5);
      end
    end
    for (int k = 0; k < 3; k++) begin
      drive(0, 0);
      chk("bub_state", st, 3);
      chk("bub_valid", sv, 0);
      chk("bub_b", b_r, 6);
      chk("bub_tw", tw2, 1);
    end
    for (int k = 7; k <= 12; k++) begin
      drive(1, k);
      if (k == 7) begin
        chk("s7_a", a_r, 3);
        chk("s7_state", st, 1);
      end
      if (k == 9) begin
        chk("s9_a", a_r, -4);
        chk("s9_tw", tw, 0);
      end
      if (k == 10) begin
        chk("s10_tw2", tw2, 1);
        chk("s10_tw", tw, 4);
      end
      if (k == 11) chk("s11_tw", tw, 0);
      if (k == 12) chk("s12_tw", tw, 4);
    end
    drive(1, 13);
    drive(1, 14);
    drive(1, 15, 1);
    chk("mrst_state", st, 0);
    chk("mrst_valid", sv, 0);
    chk("mrst_a", a_r, 0);
    chk("mrst_b", b_r, 0);
    chk("mrst_tw", tw, 0);
    chk("mrst_tw2", tw2, 0);
    for (int k = 0; k < 16; k++) begin
      drive(1, 20 + k);
      if (k == 0) chk("nf_tw", tw2, 0);
      if (k == 3) chk("nf_state3", st, 0);
      if (k == 4) chk("nf_state4", st, 1);
    end
`ifdef SDF_FLUSH_EN
    flush = 1;
    drive(0, 0);
    flush = 0;
    chk("fl_busy0", busy, 1);
    chk("fl_ready0", rdy, 0);
    for (int k = 0; k < D; k++) begin
      drive(0, 0, 0, 1);
      chk("fl_busy", busy, (k < D - 1) ? 1 : 0);
      chk("fl_ready", rdy, (k < D - 1) ? 0 : 1);
      chk("fl_state", st, 2);
      chk("fl_b", b_r, 0);
    end
    model_reset();
    flush = 1;
    drive(0, 0);
    flush = 0;
    chk("fl_ignored", busy, 0);
    drive(1, 40);
    chk("fl_next_state", st, 0);
`endif
    drive(0, 0);
    drive(0, 0);
    chk("sb_left", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
